// File: rtl/uart_work_rx_pkg.sv
// uart_work_rx_pkg: shared constants for the work-packet receiver and the miner control block.
package uart_work_rx_pkg;
   localparam int PACKET_BYTES_DEF = 76;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_BREAK = 3'd4;
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop rxd synchroniser and 8N1 byte FSM with mid-bit sampling.
module uart_rx_byte
   import uart_work_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       idle
);
   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2);
   logic [1:0]    sync_q, sync_d;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d, ferr_q, ferr_d;
   logic          rxs, expire;
   always_comb begin
      sync_d  = {sync_q[0], rxd};
      rxs     = sync_q[1];
      expire  = timer_q == TW'(1);
      state_d = state_q;
      timer_d = timer_q > TW'(1) ? timer_q - TW'(1) : timer_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         ST_IDLE: if (!rxs) begin
            timer_d = HALF;
            state_d = ST_START;
         end
         ST_START: if (expire) begin
            state_d = rxs ? ST_IDLE : ST_DATA;
            timer_d = FULL;
            idx_d   = 3'd0;
         end
         ST_DATA: if (expire) begin
            data_d  = {rxs, data_q[7:1]};
            idx_d   = idx_q + 3'd1;
            timer_d = FULL;
            state_d = idx_q == 3'd7 ? ST_STOP : ST_DATA;
         end
         ST_STOP: if (expire) begin
            valid_d = rxs;
            ferr_d  = !rxs;
            state_d = rxs ? ST_IDLE : ST_BREAK;
         end
         ST_BREAK: state_d = rxs ? ST_IDLE : ST_BREAK;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= 2'b11;
         state_q <= ST_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end
   assign rx_byte    = data_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;
   assign idle       = state_q == ST_IDLE;
endmodule

// File: rtl/uart_work_rx.sv
// uart_work_rx: assembles serial bytes into a work packet and hands it over with valid/ack.
module uart_work_rx
   import uart_work_rx_pkg::*;
#(
   parameter int CLK_HZ       = 100000000,
   parameter int BAUD         = 115200,
   parameter int PACKET_BYTES = PACKET_BYTES_DEF,
   parameter int GAP_TIMEOUT  = 100000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      rxd,
   output logic [PACKET_BYTES*8-1:0] work_data,
   output logic                      work_valid,
   input  logic                      work_ack,
   output logic                      frame_err,
   output logic                      overrun,
   output logic                      busy
);
   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int W   = PACKET_BYTES * 8;
   localparam int CW  = $clog2(PACKET_BYTES + 1);
   localparam int GW  = $clog2(GAP_TIMEOUT + 1);
   logic [7:0]    rx_byte;
   logic          byte_valid, rx_idle, done, timeout;
   logic [W-1:0]  shift_q, shift_d, data_q, data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          valid_q, valid_d, overrun_q, overrun_d;
   uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_byte (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_byte   (rx_byte),
      .byte_valid(byte_valid),
      .frame_err (frame_err),
      .idle      (rx_idle)
   );
   always_comb begin
      done      = cnt_q == CW'(PACKET_BYTES);
      timeout   = gap_q == GW'(GAP_TIMEOUT);
      shift_d   = byte_valid ? {shift_q[W-9:0], rx_byte} : shift_q;
      cnt_d     = (frame_err || done || timeout) ? '0 : byte_valid ? cnt_q + CW'(1) : cnt_q;
      gap_d     = (rx_idle && cnt_q != '0 && !timeout) ? gap_q + GW'(1) : '0;
      data_d    = done ? shift_q : data_q;
      // newest work wins: a completion always (re)asserts valid, even over a pending ack
      valid_d   = done || (valid_q && !work_ack);
      overrun_d = done && valid_q && !work_ack;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q   <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end
   assign work_data  = data_q;
   assign work_valid = valid_q;
   assign overrun    = overrun_q;
   assign busy       = !rx_idle || cnt_q != '0;
endmodule

// File: tb/tb_uart_work_rx.sv
// tb_uart_work_rx: directed 8N1 packet scenarios at 10 clocks per bit, 4-byte packets.
module tb_uart_work_rx;
   logic        clk = 1'b0, reset = 1'b1, rxd = 1'b1, work_ack = 1'b0;
   logic [31:0] work_data;
   logic        work_valid, frame_err, overrun, busy;
   int          n_checks = 0, n_fail = 0, ov_cnt = 0, fe_cnt = 0, snap = 0;
   uart_work_rx #(
      .CLK_HZ(1000000), .BAUD(100000), .PACKET_BYTES(4), .GAP_TIMEOUT(200)
   ) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .work_data(work_data), .work_valid(work_valid),
      .work_ack(work_ack), .frame_err(frame_err), .overrun(overrun), .busy(busy)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // ends one clock short of the full frame so callers can probe the completion edge
   task automatic send_bits(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(10);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(10);
      end
      rxd = stop;
      tick(9);
   endtask
   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 1'b1);
      tick(1);
   endtask
   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask
   task automatic ack_pulse();
      work_ack = 1'b1;
      tick(1);
      work_ack = 1'b0;
   endtask
   initial begin
      tick(3);
      check("rst_data", work_data, 32'h0);
      check("rst_valid", work_valid, 32'h0);
      check("rst_busy", busy, 32'h0);
      check("rst_ferr", frame_err, 32'h0);
      check("rst_overrun", overrun, 32'h0);
      reset = 1'b0;
      tick(2);
      // basic packet and 2-clock latency after the last stop sample
      send_byte(8'hDE);
      send_byte(8'hAD);
      send_byte(8'hBE);
      send_bits(8'hEF, 1'b1);
      check("s1_valid_early", work_valid, 32'h0);
      tick(1);
      check("s1_valid", work_valid, 32'h1);
      check("s1_data", work_data, 32'hDEADBEEF);
      check("s1_busy", busy, 32'h0);
      check("s1_overrun", overrun, 32'h0);
      // ack, then overrun
      ack_pulse();
      check("s2_valid_after_ack", work_valid, 32'h0);
      check("s2_data_hold", work_data, 32'hDEADBEEF);
      send_word(32'h0A0B0C0D);
      check("s2_valid3", work_valid, 32'h1);
      check("s2_data3", work_data, 32'h0A0B0C0D);
      snap = ov_cnt;
      send_word(32'h01020304);
      tick(2);
      check("s2_overrun_count", ov_cnt - snap, 32'd1);
      check("s2_data_over", work_data, 32'h01020304);
      check("s2_valid_over", work_valid, 32'h1);
      // completion coinciding with ack: no overrun, valid stays
      snap = ov_cnt;
      send_byte(8'h5A);
      send_byte(8'h5B);
      send_byte(8'h5C);
      send_bits(8'h5D, 1'b1);
      work_ack = 1'b1;
      tick(1);
      work_ack = 1'b0;
      check("s2b_valid", work_valid, 32'h1);
      check("s2b_data", work_data, 32'h5A5B5C5D);
      tick(2);
      check("s2b_no_overrun", ov_cnt - snap, 32'd0);
      // framing error discards partial packet
      ack_pulse();
      snap = fe_cnt;
      send_byte(8'h77);
      check("s3_cnt_one", dut.cnt_q, 32'd1);
      send_bits(8'h55, 1'b0);
      tick(50);
      rxd = 1'b1;
      tick(5);
      check("s3_ferr_count", fe_cnt - snap, 32'd1);
      check("s3_cnt_zero", dut.cnt_q, 32'd0);
      check("s3_busy", busy, 32'h0);
      check("s3_no_valid", work_valid, 32'h0);
      send_word(32'h11223344);
      check("s3_data", work_data, 32'h11223344);
      check("s3_valid", work_valid, 32'h1);
      // start-bit glitch
      ack_pulse();
      snap = fe_cnt;
      rxd = 1'b0;
      tick(3);
      check("s4_busy_glitch", busy, 32'h1);
      rxd = 1'b1;
      tick(10);
      check("s4_busy_drop", busy, 32'h0);
      check("s4_no_ferr", fe_cnt - snap, 32'd0);
      check("s4_cnt", dut.cnt_q, 32'd0);
      check("s4_no_valid", work_valid, 32'h0);
      // gap timeout
      send_byte(8'h12);
      send_byte(8'h34);
      tick(190);
      check("s5_cnt_held", dut.cnt_q, 32'd2);
      check("s5_busy_held", busy, 32'h1);
      tick(60);
      check("s5_cnt_cleared", dut.cnt_q, 32'd0);
      check("s5_busy_cleared", busy, 32'h0);
      send_word(32'hAABBCCDD);
      check("s5_data", work_data, 32'hAABBCCDD);
      check("s5_valid", work_valid, 32'h1);
      // reset mid byte 3 of a packet, valid still pending
      send_byte(8'hC1);
      send_byte(8'hC2);
      rxd = 1'b0;
      tick(10);
      rxd = 1'b1;
      tick(25);
      reset = 1'b1;
      tick(2);
      check("s6_rst_data", work_data, 32'h0);
      check("s6_rst_valid", work_valid, 32'h0);
      check("s6_rst_busy", busy, 32'h0);
      check("s6_rst_ferr", frame_err, 32'h0);
      check("s6_rst_overrun", overrun, 32'h0);
      reset = 1'b0;
      tick(2);
      snap = ov_cnt;
      send_word(32'hCAFEF00D);
      check("s6_data", work_data, 32'hCAFEF00D);
      check("s6_valid", work_valid, 32'h1);
      tick(2);
      check("s6_no_overrun", ov_cnt - snap, 32'd0);
      check("s6_cnt", dut.cnt_q, 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
